bram_copy_dma: RTL and testbench
================================

# bram_copy_dma

Block-copy engine that acts as the initiator on both ports of the 16-bit true dual-port BRAM. It reads a contiguous run of words through port A and writes them to a destination range through port B. It sustains one word per cycle by exploiting the BRAM's 1-cycle synchronous read latency. It sits between the control FSM/CPU register interface and the shared BRAM, and moves buffers without stalling the datapath.

## Interface
- ADDR_WIDTH, 9, BRAM address width (depth 2^ADDR_WIDTH words of 16 bits)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request a copy; sampled only in IDLE
- abort  in  1  stop issuing reads; in-flight write completes
- src_addr  in  ADDR_WIDTH  first source word address (captured at start)
- dst_addr  in  ADDR_WIDTH  first destination word address (captured at start)
- len  in  ADDR_WIDTH+1  words to copy, 0..2^ADDR_WIDTH (captured at start)
- busy  out  1  high from cycle after accepted start until done pulse
- done  out  1  one-cycle pulse at completion or abort
- aborted  out  1  valid with done; 1 if the copy ended by abort; holds until next start
- count  out  ADDR_WIDTH+1  words written so far in current/last copy; holds after done
- en_a, we_a  out  1 each  BRAM port A enable / write enable (we_a constant 0)
- addr_a  out  ADDR_WIDTH  BRAM port A address
- dout_a  in  16  BRAM port A read data (valid 1 cycle after en_a)
- en_b, we_b  out  1 each  BRAM port B enable / write enable (always equal)
- addr_b  out  ADDR_WIDTH  BRAM port B address
- din_b  out  16  BRAM port B write data; wired directly from dout_a

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: if start=1, latch src/dst/len, clear count and aborted. If len=0, go to FIN. Otherwise set en_a=1, addr_a=src_addr, rd_left=len-1, and go to RUN.
- RUN: each cycle, the previous read returns and en_b=we_b=1 with addr_b=dst pointer; the dst pointer increments. If rd_left≠0 and abort=0, issue the next read at addr_a+1 and decrement rd_left. Otherwise drop en_a and go to DRAIN.
- DRAIN: perform the final write, then go to FIN.
- FIN: done=1 for one cycle, busy drops, return to IDLE.
- abort in RUN: no further reads are issued; the write for the read already in flight still happens (count includes it); aborted=1. abort in IDLE, DRAIN or FIN is ignored.
- Addresses wrap modulo 2^ADDR_WIDTH (511+1 → 0). len=512 copies the whole memory.
- count increments on every cycle with we_b=1.
- start while busy is ignored.
- Overlap: dst=src and dst<src (forward copy) are supported. dst in src+1..src+len-1 (mod depth) is unsupported, because the port-collision result is undefined; the block does not detect it.
- Outputs are registered except din_b.

## Timing
- Reset values: busy=0, done=0, aborted=0, count=0, en_a=we_a=en_b=we_b=0, addr_a=addr_b=0; state=IDLE. Reset mid-copy forces these immediately. Memory is left partially written; no further writes are issued.
- Cycle 0: start sampled. Cycle 1: busy=1, en_a=1, addr_a=src.
- Cycle k (1≤k≤len): read of src+k-1. Cycle k+1: write of dst+k-1 with din_b = dout_a.
- Last write at cycle len+1. done=1 at cycle len+2, busy=0 from cycle len+2.
- Total: len+2 cycles from start to done. len=0: done at cycle 1, no BRAM enables.
- abort sampled high at cycle j in RUN (its read at cycle j is already issued): last write at j+1, done at j+2, count=j.
- New start is accepted in the cycle done is high? No: done is in FIN; start is accepted from the following IDLE cycle.

## Test plan
- Preload mem[0..7]=0x1000..0x1007. Copy src=0, dst=100, len=8 → mem[100..107]=0x1000..0x1007, done at cycle 10, count=8, aborted=0, one write per cycle on cycles 2–9.
- len=0 → done at cycle 1, en_a/en_b never asserted, count=0.
- Wrap: src=508, dst=2, len=6, mem[508..511,0,1] patterned → dst 2..7 correct; addr_a sequence 508,509,510,511,0,1.
- Abort: len=20, abort high at cycle 5 → exactly 5 writes (dst..dst+4), done at cycle 7, aborted=1, count=5.
- Reset asserted at cycle 4 of a len=10 copy → all outputs 0 the same cycle, no enables afterward; new copy after reset completes normally.
- start pulsed again while busy → ignored; the first copy's results and done timing are unchanged.

Source files
------------

// File: rtl/bram_copy_dma.sv
// Block-copy engine driving both ports of a 16-bit true dual-port BRAM.
// Port A streams reads from the source range; port B writes each word one
// cycle later to the destination range, giving one word per cycle.
module bram_copy_dma #(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  en_a,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [15:0]           dout_a,
    output logic                  en_b,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [15:0]           din_b
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t                state_q,   state_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  aborted_q, aborted_d;
    logic                  en_a_q,    en_a_d;
    logic                  en_b_q,    en_b_d;
    logic [ADDR_WIDTH-1:0] addr_a_q,  addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q,  addr_b_d;
    logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_left_q, rd_left_d;
    logic [ADDR_WIDTH:0]   count_q,   count_d;

    // Next-state and registered-output computation for the copy sequencer.
    // Each RUN cycle schedules the write for the read issued that cycle, so
    // the write lands exactly when the BRAM returns the read data.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        en_a_d    = 1'b0;
        en_b_d    = 1'b0;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        dst_ptr_d = dst_ptr_q;
        rd_left_d = rd_left_q;
        count_d   = count_q + CW'(en_b_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d   = '0;
                    aborted_d = 1'b0;
                    dst_ptr_d = dst_addr;
                    if (len == '0) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        busy_d    = 1'b1;
                        en_a_d    = 1'b1;
                        addr_a_d  = src_addr;
                        // len of 2^ADDR_WIDTH has zero low bits; wrapping gives all-ones
                        rd_left_d = len[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                en_b_d    = 1'b1;
                addr_b_d  = dst_ptr_q;
                dst_ptr_d = dst_ptr_q + ADDR_WIDTH'(1);
                if (rd_left_q != '0 && !abort) begin
                    en_a_d    = 1'b1;
                    addr_a_d  = addr_a_q + ADDR_WIDTH'(1);
                    rd_left_d = rd_left_q - ADDR_WIDTH'(1);
                end else begin
                    state_d = DRAIN;
                end
                if (abort && rd_left_q != '0) begin
                    aborted_d = 1'b1;
                end
            end
            DRAIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            en_a_q    <= 1'b0;
            en_b_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            dst_ptr_q <= '0;
            rd_left_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            en_a_q    <= en_a_d;
            en_b_q    <= en_b_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            dst_ptr_q <= dst_ptr_d;
            rd_left_q <= rd_left_d;
            count_q   <= count_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign count   = count_q;
    assign en_a    = en_a_q;
    assign we_a    = 1'b0;
    assign addr_a  = addr_a_q;
    assign en_b    = en_b_q;
    assign we_b    = en_b_q;
    assign addr_b  = addr_b_q;
    assign din_b   = dout_a;

endmodule

// File: tb/tb_bram_copy_dma.sv
// Self-checking bench for bram_copy_dma with a behavioural BRAM and a
// cycle-indexed model of the copy derived from src/dst/len/abort.
module tb_bram_copy_dma;

    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   count;
    logic          en_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [15:0]   dout_a;
    logic          en_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [15:0]   din_b;

    always #5 clk = ~clk;

    bram_copy_dma #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .count    (count),
        .en_a     (en_a),
        .we_a     (we_a),
        .addr_a   (addr_a),
        .dout_a   (dout_a),
        .en_b     (en_b),
        .we_b     (we_b),
        .addr_b   (addr_b),
        .din_b    (din_b)
    );

    // Behavioural dual-port BRAM: 1-cycle read on A, write on B, bench preload port.
    logic [15:0]   mem [DEPTH];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [15:0]   pre_data;

    always @(posedge clk) begin
        if (en_a) dout_a <= mem[addr_a];
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (en_b && we_b) mem[addr_b] <= din_b;
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mode = 2;   // 0 idle, 1 copy in progress, 2 reset (all zero)
    int          m_src, m_dst, m_len, m_n;
    bit          m_abort;
    int          m_count_hold = 0;
    bit          m_aborted_hold = 1'b0;
    int          obs_done_cyc = -1;
    int          addr_a_log[$];
    logic [15:0] snap [DEPTH];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: cycle c after start reads src+c-1 for c<=n and writes dst+c-2 for 2<=c<=n+1.
    task automatic compare_cycle();
        bit ea, eb, ebusy, edone;
        int e_cnt;
        ea = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b0;
        e_cnt = (mode == 2) ? 0 : m_count_hold;
        if (mode == 1) begin
            if (m_len == 0) begin
                edone = (cyc == 1);
                e_cnt = 0;
            end else begin
                ea    = (cyc <= m_n);
                eb    = (cyc >= 2 && cyc <= m_n + 1);
                ebusy = (cyc <= m_n + 1);
                edone = (cyc == m_n + 2);
                e_cnt = (cyc < 2) ? 0 : ((cyc - 2 > m_n) ? m_n : cyc - 2);
            end
            if (cyc == 1) begin
                obs_done_cyc = -1;
                addr_a_log.delete();
            end
            if (done) obs_done_cyc = cyc;
            if (en_a) addr_a_log.push_back(int'(addr_a));
        end
        chk("en_a", int'(en_a), int'(ea));
        chk("we_a", int'(we_a), 0);
        chk("en_b", int'(en_b), int'(eb));
        chk("we_b", int'(we_b), int'(eb));
        chk("busy", int'(busy), int'(ebusy));
        chk("done", int'(done), int'(edone));
        chk("count", int'(count), e_cnt);
        if (mode == 1) begin
            if (ea) chk("addr_a", int'(addr_a), (m_src + cyc - 1) % DEPTH);
            if (eb) begin
                chk("addr_b", int'(addr_b), (m_dst + cyc - 2) % DEPTH);
                chk("din_b", int'(din_b), int'(snap[(m_src + cyc - 2) % DEPTH]));
            end
            if (cyc >= ((m_len == 0) ? 1 : m_n + 2))
                chk("aborted", int'(aborted), int'(m_abort));
        end else begin
            chk("aborted", int'(aborted), (mode == 2) ? 0 : int'(m_aborted_hold));
            if (mode == 2) begin
                chk("rst_addr_a", int'(addr_a), 0);
                chk("rst_addr_b", int'(addr_b), 0);
            end
        end
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic setup_model(input int src, input int dst, input int ln, input int abort_cyc);
        for (int a = 0; a < DEPTH; a++) snap[a] = mem[a];
        m_src   = src;
        m_dst   = dst;
        m_len   = ln;
        m_abort = (abort_cyc != 0 && abort_cyc < ln);
        m_n     = m_abort ? abort_cyc : ln;
        src_addr = AW'(src);
        dst_addr = AW'(dst);
        len      = (AW+1)'(ln);
    endtask

    task automatic run_copy(input int src, input int dst, input int ln,
                            input int abort_cyc, input int restart_cyc);
        int last;
        logic [15:0] expm [DEPTH];
        setup_model(src, dst, ln, abort_cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1;
        last  = (ln == 0) ? 2 : m_n + 3;
        for (int c = 1; c <= last; c++) begin
            cyc   = c;
            abort = (abort_cyc != 0 && c == abort_cyc);
            start = (restart_cyc != 0 && c == restart_cyc);
            if (start) src_addr = AW'(src + 37);
            @(posedge clk); #1;
        end
        abort          = 1'b0;
        start          = 1'b0;
        src_addr       = AW'(src);
        m_count_hold   = m_n;
        m_aborted_hold = m_abort;
        mode           = 0;
        for (int a = 0; a < DEPTH; a++) expm[a] = snap[a];
        for (int i = 0; i < m_n; i++) expm[(dst + i) % DEPTH] = snap[(src + i) % DEPTH];
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("mem[%0d]", a), int'(mem[a]), int'(expm[a]));
    endtask

    initial begin
        int wrap_seq [6];
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        for (int a = 0; a < DEPTH; a++) preload(a, 16'h5A00 ^ 16'(a));
        reset = 1'b0;
        mode  = 0;
        idle(2);

        // Basic 8-word copy.
        for (int i = 0; i < 8; i++) preload(i, 16'h1000 + 16'(i));
        run_copy(0, 100, 8, 0, 0);
        chk("t1_done_cycle", obs_done_cyc, 10);
        chk("t1_count", int'(count), 8);
        chk("t1_aborted", int'(aborted), 0);
        for (int i = 0; i < 8; i++)
            chk("t1_mem", int'(mem[100 + i]), 32'h1000 + i);
        idle(1);

        // Zero-length copy.
        run_copy(5, 6, 0, 0, 0);
        chk("t2_done_cycle", obs_done_cyc, 1);
        chk("t2_reads", addr_a_log.size(), 0);
        chk("t2_count", int'(count), 0);
        idle(1);

        // Source range wraps past the top of memory.
        for (int i = 0; i < 4; i++) preload(508 + i, 16'hB000 + 16'(i));
        preload(0, 16'hB004);
        preload(1, 16'hB005);
        run_copy(508, 2, 6, 0, 0);
        wrap_seq = '{508, 509, 510, 511, 0, 1};
        chk("t3_reads", addr_a_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < addr_a_log.size()) chk("t3_addr_a_seq", addr_a_log[i], wrap_seq[i]);
        for (int i = 0; i < 6; i++)
            chk("t3_mem", int'(mem[2 + i]), 32'hB000 + i);
        chk("t3_done_cycle", obs_done_cyc, 8);
        idle(1);

        // Abort at cycle 5 of a 20-word copy.
        run_copy(200, 300, 20, 5, 0);
        chk("t4_done_cycle", obs_done_cyc, 7);
        chk("t4_count", int'(count), 5);
        chk("t4_aborted", int'(aborted), 1);
        chk("t4_last_write", int'(mem[304]), 32'h5ACC);
        chk("t4_not_written", int'(mem[305]), 32'h5B31);
        idle(1);

        // Reset asserted in cycle 4 of a 10-word copy.
        setup_model(40, 60, 10, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1;
        for (int c = 1; c <= 3; c++) begin
            cyc = c;
            @(posedge clk); #1;
        end
        cyc   = 4;
        reset = 1'b1;
        mode  = 2;
        idle(2);
        reset          = 1'b0;
        m_count_hold   = 0;
        m_aborted_hold = 1'b0;
        mode           = 0;
        idle(4);
        run_copy(40, 60, 10, 0, 0);
        chk("t5_done_cycle", obs_done_cyc, 12);
        chk("t5_count", int'(count), 10);
        idle(1);

        // Second start pulse while busy must be ignored.
        run_copy(10, 150, 6, 0, 3);
        chk("t6_done_cycle", obs_done_cyc, 8);
        chk("t6_count", int'(count), 6);
        chk("t6_first", int'(mem[150]), 32'h5A0A);
        chk("t6_last", int'(mem[155]), 32'h5A0F);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
